// File: rtl/jpg.sv
// jpg: buffers one R/G/B planar block (4 px/word) and streams Y, Cb, Cr planes; `JPG_LEVEL_SHIFT_EN outputs value-128 as int8.
// Latency: first output word 1 cycle after the B-plane closing beat; input stalls (tready=0) while sending, output holds under tready=0.
module jpg #(
   parameter integer C_S00_AXIS_TDATA_WIDTH = 32,
   parameter integer C_M00_AXIS_TDATA_WIDTH = 32,
   parameter integer C_M00_AXIS_START_COUNT = 32,
   parameter integer MAX_WORDS              = 16
) (
   input  logic                                  aclk,
   input  logic                                  areset,
   output logic                                  s00_axis_tready,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
   input  logic                                  s00_axis_tlast,
   input  logic                                  s00_axis_tvalid,
   output logic                                  m00_axis_tvalid,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
   output logic                                  m00_axis_tlast,
   input  logic                                  m00_axis_tready
);

   localparam integer DW    = C_S00_AXIS_TDATA_WIDTH;
   localparam integer BYTES = DW / 8;
   localparam integer AW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam integer NW    = $clog2(MAX_WORDS + 1);

   localparam logic [1:0] RECV_R = 2'd0;
   localparam logic [1:0] RECV_G = 2'd1;
   localparam logic [1:0] RECV_B = 2'd2;
   localparam logic [1:0] SEND   = 2'd3;

   logic [1:0]    state;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic [1:0]    rd_pl;
   logic [NW-1:0] blk_n;
   logic          rdy_q;
   logic [DW-1:0] r_buf [MAX_WORDS];
   logic [DW-1:0] g_buf [MAX_WORDS];
   logic [DW-1:0] b_buf [MAX_WORDS];

   logic          beat;
   logic          plane_end;
   logic          keep_word;
   logic          load;
   logic          rd_last_idx;
   logic [DW-1:0] conv_dat;
   logic [DW-1:0] r_w, g_w, b_w;
   logic          unused_sig;

   assign unused_sig      = ^{s00_axis_tstrb, C_M00_AXIS_START_COUNT[0]};
   assign s00_axis_tready = rdy_q;
   assign m00_axis_tstrb  = '1;

   assign beat        = s00_axis_tvalid && rdy_q;
   assign plane_end   = beat && (s00_axis_tlast || (wr_idx == AW'(MAX_WORDS - 1)));
   assign keep_word   = NW'(wr_idx) < blk_n;
   assign load        = !m00_axis_tvalid || m00_axis_tready;
   assign rd_last_idx = (NW'(rd_idx) + NW'(1)) == blk_n;

   assign r_w = r_buf[rd_idx];
   assign g_w = g_buf[rd_idx];
   assign b_w = b_buf[rd_idx];

   function automatic logic [7:0] conv_px(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b, input logic [1:0] sel);
      logic signed [19:0] rs, gs, bs, acc;
      logic [7:0]         res;
      rs = signed'({12'd0, r});
      gs = signed'({12'd0, g});
      bs = signed'({12'd0, b});
      case (sel)
         2'd0:    acc = (20'sd77 * rs + 20'sd150 * gs + 20'sd29 * bs + 20'sd128) >>> 8;
         2'd1:    acc = ((20'sd128 * bs - 20'sd43 * rs - 20'sd85 * gs + 20'sd128) >>> 8) + 20'sd128;
         default: acc = ((20'sd128 * rs - 20'sd107 * gs - 20'sd21 * bs + 20'sd128) >>> 8) + 20'sd128;
      endcase
      if (acc < 20'sd0)        res = 8'h00;
      else if (acc > 20'sd255) res = 8'hFF;
      else                     res = acc[7:0];
`ifdef JPG_LEVEL_SHIFT_EN
      // value-128 as int8 is the unsigned value with its MSB flipped
      conv_px = res ^ 8'h80;
`else
      conv_px = res;
`endif
   endfunction

   always_comb begin
      conv_dat = '0;
      for (int i = 0; i < BYTES; i++) begin
         conv_dat[8*i +: 8] = conv_px(r_w[8*i +: 8], g_w[8*i +: 8], b_w[8*i +: 8], rd_pl);
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state           <= RECV_R;
         wr_idx          <= '0;
         rd_idx          <= '0;
         rd_pl           <= 2'd0;
         blk_n           <= '0;
         rdy_q           <= 1'b0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         m00_axis_tdata  <= '0;
         for (int k = 0; k < MAX_WORDS; k++) begin
            r_buf[k] <= '0;
            g_buf[k] <= '0;
            b_buf[k] <= '0;
         end
      end else begin
         case (state)
            RECV_R: begin
               rdy_q <= 1'b1;
               if (beat) begin
                  r_buf[wr_idx] <= s00_axis_tdata;
                  wr_idx        <= wr_idx + AW'(1);
               end
               if (plane_end) begin
                  blk_n  <= NW'(wr_idx) + NW'(1);
                  wr_idx <= '0;
                  state  <= RECV_G;
               end
            end
            RECV_G: begin
               rdy_q <= 1'b1;
               if (beat && keep_word) g_buf[wr_idx] <= s00_axis_tdata;
               if (beat)              wr_idx <= wr_idx + AW'(1);
               if (plane_end) begin
                  wr_idx <= '0;
                  state  <= RECV_B;
               end
            end
            RECV_B: begin
               rdy_q <= !plane_end;
               if (beat && keep_word) b_buf[wr_idx] <= s00_axis_tdata;
               if (beat)              wr_idx <= wr_idx + AW'(1);
               if (plane_end) begin
                  wr_idx <= '0;
                  rd_idx <= '0;
                  rd_pl  <= 2'd0;
                  state  <= SEND;
               end
            end
            SEND: begin
               if (load) begin
                  if (rd_pl != 2'd3) begin
                     m00_axis_tdata  <= conv_dat;
                     m00_axis_tvalid <= 1'b1;
                     m00_axis_tlast  <= (rd_pl == 2'd2) && rd_last_idx;
                     if (rd_last_idx) begin
                        rd_idx <= '0;
                        rd_pl  <= rd_pl + 2'd1;
                     end else begin
                        rd_idx <= rd_idx + AW'(1);
                     end
                  end else begin
                     // final word accepted: clear buffers so short G/B planes of the next block read as zero
                     m00_axis_tvalid <= 1'b0;
                     m00_axis_tlast  <= 1'b0;
                     rd_pl           <= 2'd0;
                     rdy_q           <= 1'b1;
                     state           <= RECV_R;
                     for (int k = 0; k < MAX_WORDS; k++) begin
                        r_buf[k] <= '0;
                        g_buf[k] <= '0;
                        b_buf[k] <= '0;
                     end
                  end
               end
            end
            default: state <= RECV_R;
         endcase
      end
   end

endmodule

// File: tb/tb_jpg.sv
// Randomized scoreboard bench for jpg: expected words queued at block issue, a monitor compares each output handshake.
module tb_jpg;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        s00_axis_tready;
   logic [31:0] s00_axis_tdata = '0;
   logic [3:0]  s00_axis_tstrb = 4'hF;
   logic        s00_axis_tlast = 1'b0;
   logic        s00_axis_tvalid = 1'b0;
   logic        m00_axis_tvalid;
   logic [31:0] m00_axis_tdata;
   logic [3:0]  m00_axis_tstrb;
   logic        m00_axis_tlast;
   logic        m00_axis_tready = 1'b1;

   always #5 aclk = ~aclk;

   jpg dut (
      .aclk(aclk), .areset(areset),
      .s00_axis_tready(s00_axis_tready), .s00_axis_tdata(s00_axis_tdata),
      .s00_axis_tstrb(s00_axis_tstrb), .s00_axis_tlast(s00_axis_tlast),
      .s00_axis_tvalid(s00_axis_tvalid),
      .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata),
      .m00_axis_tstrb(m00_axis_tstrb), .m00_axis_tlast(m00_axis_tlast),
      .m00_axis_tready(m00_axis_tready)
   );

   int          checks = 0;
   int          errors = 0;
   logic [32:0] exp_q[$];
   int          blk_out = 0;
   int          hs_cnt = 0;
   int          stall_mode = 0;
   int          stall_left = 0;
   bit          gaps_en = 1'b0;
   logic [31:0] rw[16];
   logic [31:0] gw[16];
   logic [31:0] bw[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int floor_div256(input int x);
      if (x >= 0) return x / 256;
      return -((-x + 255) / 256);
   endfunction

   function automatic logic [7:0] ref_px(input int r, input int g, input int b, input int sel);
      int v;
      case (sel)
         0:       v = floor_div256(77 * r + 150 * g + 29 * b + 128);
         1:       v = floor_div256(-43 * r - 85 * g + 128 * b + 128) + 128;
         default: v = floor_div256(128 * r - 107 * g - 21 * b + 128) + 128;
      endcase
      if (v < 0) v = 0;
      if (v > 255) v = 255;
`ifdef JPG_LEVEL_SHIFT_EN
      v = (v - 128) & 255;
`endif
      return v[7:0];
   endfunction

   task automatic push_expected(input int nr, input int ng, input int nb);
      int          n;
      logic [31:0] w;
      logic [31:0] gv, bv;
      n = (nr > 16) ? 16 : nr;
      for (int pl = 0; pl < 3; pl++) begin
         for (int k = 0; k < n; k++) begin
            gv = (k < ng) ? gw[k] : 32'd0;
            bv = (k < nb) ? bw[k] : 32'd0;
            for (int i = 0; i < 4; i++)
               w[8*i +: 8] = ref_px(int'(rw[k][8*i +: 8]), int'(gv[8*i +: 8]), int'(bv[8*i +: 8]), pl);
            exp_q.push_back({(pl == 2) && (k == n - 1), w});
         end
      end
   endtask

   task automatic send_plane(input int which, input int cnt, input bit tl);
      int to;
      for (int k = 0; k < cnt; k++) begin
         if (gaps_en && ($urandom_range(0, 3) == 0)) begin
            s00_axis_tvalid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge aclk);
            #1;
         end
         s00_axis_tdata  = (which == 0) ? rw[k] : (which == 1) ? gw[k] : bw[k];
         s00_axis_tlast  = tl && (k == cnt - 1);
         s00_axis_tvalid = 1'b1;
         to = 0;
         while (!s00_axis_tready && to < 2000) begin
            @(posedge aclk);
            #1;
            to++;
         end
         if (to >= 2000) begin
            checks++;
            errors++;
            $display("FAIL s_tready_timeout actual=0 required=1 at %0t", $time);
         end
         @(posedge aclk);
         #1;
      end
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
   endtask

   task automatic run_block(input int nr, input int ng, input int nb,
                            input bit tlr, input bit tlg, input bit tlb);
      int n;
      int to;
      n = (nr > 16) ? 16 : nr;
      blk_out = 0;
      push_expected(nr, ng, nb);
      send_plane(0, nr, tlr);
      send_plane(1, ng, tlg);
      send_plane(2, nb, tlb);
      to = 0;
      while (exp_q.size() > 0 && to < 3000) begin
         @(posedge aclk);
         to++;
      end
      if (to >= 3000) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d required=0 words left", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge aclk);
      #1;
      chk("block_word_count", 64'(blk_out), 64'(3 * n));
      chk("idle_after_block", {63'd0, m00_axis_tvalid}, 64'd0);
   endtask

   task automatic fill_ramp();
      for (int k = 0; k < 16; k++)
         for (int i = 0; i < 4; i++) begin
            rw[k][8*i +: 8] = 8'(4 * k + i);
            gw[k][8*i +: 8] = 8'(16 + 4 * k + i);
            bw[k][8*i +: 8] = 8'(32 + 4 * k + i);
         end
   endtask

   task automatic fill_const(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      for (int k = 0; k < 16; k++) begin
         rw[k] = {4{r}};
         gw[k] = {4{g}};
         bw[k] = {4{b}};
      end
   endtask

   task automatic fill_rand();
      for (int k = 0; k < 16; k++) begin
         rw[k] = $urandom;
         gw[k] = $urandom;
         bw[k] = $urandom;
      end
   endtask

   // monitor: sample at negedge, update downstream ready just after the following posedge
   initial begin : monitor
      bit          stalled;
      logic [32:0] held;
      logic [32:0] e;
      bit          hs;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge aclk);
         hs = 1'b0;
         if (areset) begin
            stalled = 1'b0;
         end else begin
            if (stalled)
               chk("hold_stable", {30'd0, m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata},
                   {30'd0, 1'b1, held});
            if (m00_axis_tvalid && m00_axis_tready) begin
               hs = 1'b1;
               blk_out++;
               hs_cnt++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word actual=%0h required=none", m00_axis_tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_word", {31'd0, m00_axis_tlast, m00_axis_tdata}, {31'd0, e});
               end
               stalled = 1'b0;
            end else begin
               stalled = m00_axis_tvalid;
            end
            held = {m00_axis_tlast, m00_axis_tdata};
         end
         @(posedge aclk);
         #1;
         case (stall_mode)
            1: begin
               if (hs && (hs_cnt % 9 == 0)) stall_left = 2;
               if (stall_left > 0) begin
                  m00_axis_tready = 1'b0;
                  stall_left--;
               end else begin
                  m00_axis_tready = 1'b1;
               end
            end
            2:       m00_axis_tready = ($urandom_range(0, 3) != 0);
            default: m00_axis_tready = 1'b1;
         endcase
      end
   end

   initial begin : stim
      int nr, ng, nb;
      bit tlr, tlg, tlb;
      int to;
      areset = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_s_tready", {63'd0, s00_axis_tready}, 64'd0);
      chk("rst_m_tvalid", {63'd0, m00_axis_tvalid}, 64'd0);
      chk("rst_m_tlast", {63'd0, m00_axis_tlast}, 64'd0);
      chk("rst_m_tdata", {32'd0, m00_axis_tdata}, 64'd0);
      chk("m_tstrb", {60'd0, m00_axis_tstrb}, 64'hF);
      areset = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      chk("post_rst_s_tready", {63'd0, s00_axis_tready}, 64'd1);
      chk("post_rst_m_tvalid", {63'd0, m00_axis_tvalid}, 64'd0);

      // ramp block, 4-word planes, ready held high
      stall_mode = 0;
      fill_ramp();
      run_block(4, 4, 4, 1, 1, 1);

      // uniform gray
      fill_const(8'd100, 8'd100, 8'd100);
      run_block(4, 4, 4, 1, 1, 1);

      // ready dropped for 2 cycles after every 9th handshake
      stall_mode = 1;
      hs_cnt = 0;
      fill_ramp();
      run_block(4, 4, 4, 1, 1, 1);

      // R plane closes on word count alone
      stall_mode = 0;
      fill_rand();
      run_block(16, 16, 16, 0, 1, 1);

      // pure red saturates Cr
      fill_const(8'd255, 8'd0, 8'd0);
      run_block(4, 4, 4, 1, 1, 1);

      // random lengths, gaps, backpressure; G/B may be short or long
      gaps_en = 1'b1;
      stall_mode = 2;
      for (int t = 0; t < 10; t++) begin
         fill_rand();
         nr = $urandom_range(1, 16);
         ng = $urandom_range(1, 16);
         nb = $urandom_range(1, 16);
         tlr = (nr < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         tlg = (ng < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         tlb = (nb < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         run_block(nr, ng, nb, tlr, tlg, tlb);
      end
      gaps_en = 1'b0;

      // reset in the middle of SEND, then a clean block
      fill_rand();
      push_expected(8, 8, 8);
      send_plane(0, 8, 1);
      send_plane(1, 8, 1);
      send_plane(2, 8, 1);
      to = 0;
      while (!m00_axis_tvalid && to < 100) begin
         @(posedge aclk);
         #1;
         to++;
      end
      chk("send_started", {63'd0, m00_axis_tvalid}, 64'd1);
      @(posedge aclk);
      #1;
      areset = 1'b1;
      @(posedge aclk);
      #1;
      chk("abort_m_tvalid", {63'd0, m00_axis_tvalid}, 64'd0);
      chk("abort_s_tready", {63'd0, s00_axis_tready}, 64'd0);
      exp_q.delete();
      @(posedge aclk);
      #1;
      areset = 1'b0;
      stall_mode = 0;
      repeat (2) @(posedge aclk);
      #1;
      chk("abort_recover_tready", {63'd0, s00_axis_tready}, 64'd1);
      fill_ramp();
      run_block(4, 4, 4, 1, 1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
